// File: rtl/ext_stage_pkg.sv
// Shared CPU definitions for the immediate/load extension stage: mode encodings
// and a width helper used by the interface and the datapath.
package ext_stage_pkg;

    typedef enum logic [2:0] {
        MODE_ZERO = 3'd0,
        MODE_SIGN = 3'd1,
        MODE_LUI  = 3'd2,
        MODE_LB   = 3'd3,
        MODE_LBU  = 3'd4,
        MODE_LH   = 3'd5,
        MODE_LHU  = 3'd6,
        MODE_RSVD = 3'd7
    } ext_mode_e;

    localparam int CNT_W = 16;

    // Width of a byte offset inside a data_w-bit word.
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ext_stage_if.sv
// Request and result channels of the extension stage, including the flush
// control and the completed-transfer counter.
interface ext_stage_if
    import ext_stage_pkg::*;
#(
    parameter int DATA_W = 32
);
    localparam int OFF_W = off_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_mode;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_off;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic [CNT_W-1:0]  out_cnt;

    modport slave (
        input  in_valid, in_mode, in_data, in_off, flush, out_ready,
        output in_ready, out_valid, out_data, out_err, out_cnt
    );

    modport master (
        output in_valid, in_mode, in_data, in_off, flush, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_cnt
    );

endinterface

// File: rtl/ext_stage_core.sv
// Combinational extension unit: immediate zero/sign/upper placement and
// byte/halfword lane selection with sign or zero extension.
module ext_core
    import ext_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = off_w(DATA_W)
) (
    input  ext_mode_e         mode_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [OFF_W-1:0]  off_i,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    logic [IMM_W-1:0] imm;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    assign imm    = data_i[IMM_W-1:0];
    assign lane_b = data_i[{off_i, 3'b000} +: 8];
    // The halfword lane ignores off_i[0]; a set bit is reported as misaligned.
    assign lane_h = data_i[{off_i[OFF_W-1:1], 4'b0000} +: 16];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        unique case (mode_i)
            MODE_ZERO: data_o = {{(DATA_W-IMM_W){1'b0}}, imm};
            MODE_SIGN: data_o = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            MODE_LUI:  data_o = {imm, {(DATA_W-IMM_W){1'b0}}};
            MODE_LB:   data_o = {{(DATA_W-8){lane_b[7]}}, lane_b};
            MODE_LBU:  data_o = {{(DATA_W-8){1'b0}}, lane_b};
            MODE_LH: begin
                data_o = {{(DATA_W-16){lane_h[15]}}, lane_h};
                err_o  = off_i[0];
            end
            MODE_LHU: begin
                data_o = {{(DATA_W-16){1'b0}}, lane_h};
                err_o  = off_i[0];
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ext_stage.sv
// One-deep registered extension stage: valid/ready handshake with flush,
// flop-driven result channel and a wrapping output-transfer counter.
module ext_stage
    import ext_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic      clk,
    input  logic      reset,
    ext_stage_if.slave bus
);

    localparam int OFF_W = off_w(DATA_W);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] core_data;
    logic              core_err;
    logic              in_fire;
    logic              out_fire;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .OFF_W  (OFF_W)
    ) u_core (
        .mode_i (ext_mode_e'(bus.in_mode)),
        .data_i (bus.in_data),
        .off_i  (bus.in_off),
        .data_o (core_data),
        .err_o  (core_err)
    );

    // Ready looks through to out_ready so a draining slot refills in the same cycle.
    assign bus.in_ready = (!valid_q || bus.out_ready) && !bus.flush;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = valid_q && bus.out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        // A result leaving together with a flush still counts as delivered.
        cnt_d   = cnt_q + CNT_W'(out_fire);
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (in_fire) begin
            valid_d = 1'b1;
            data_d  = core_data;
            err_d   = core_err;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the data and error flops are reset too, since their reset value is observable on the ports.
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_err   = err_q;
    assign bus.out_cnt   = cnt_q;

endmodule
